// File: rtl/lane_sched_pkg.sv
// rtl/lane_sched_pkg.sv - shared types and constants for the lane tick scheduler
//
// Purpose : scheduler state encoding and per-lane base move periods.
// Contents: sched_state_e  - IDLE / RUN / PAUSE / OVER
//           BASE_PERIOD    - base period (in base_ticks) of each lane at level 0
//           MIN_PERIOD     - floor for a lane period once the level eats into it
package lane_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } sched_state_e;

  // Lane 0 is the first entry.
  localparam int BASE_PERIOD [4] = '{8, 6, 10, 5};

  localparam int MIN_PERIOD = 1;

endpackage

// File: rtl/lane_tick_scheduler_rr_arbiter.sv
// rtl/lane_tick_scheduler_rr_arbiter.sv - round-robin one-hot lane arbiter
//
// Purpose: picks the first requesting lane at or above rr_ptr (with wrap) and
//          returns the pointer value that follows it. Purely combinational;
//          the parent registers grant and pointer.
// Ports  : req      in  NUM_LANES  pending lane requests
//          rr_ptr   in  PTR_W      lane with highest priority this cycle
//          grant    out NUM_LANES  one-hot grant, zero when req is zero
//          next_ptr out PTR_W      grant index + 1 mod NUM_LANES (rr_ptr if idle)
module rr_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [PTR_W-1:0]     next_ptr
);

  int              sum;
  logic [PTR_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester at or
  // above rr_ptr is the last writer and therefore wins.
  always_comb begin
    grant    = '0;
    next_ptr = rr_ptr;
    sum      = 0;
    idx      = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_LANES) sum = sum - NUM_LANES;
      idx = PTR_W'(sum);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        next_ptr   = (sum == NUM_LANES - 1) ? '0 : PTR_W'(sum + 1);
      end
    end
  end

endmodule

// File: rtl/lane_tick_scheduler.sv
// rtl/lane_tick_scheduler.sv - per-lane car-move strobe scheduler
//
// Purpose: owns the slow-tick prescaler and one period down-counter per road
//          lane, and hands out at most one lane move per cycle (round-robin)
//          so the shared lane-shift/LED update logic is never double-booked.
//          Driven by the game FSM through start/pause/level_up/game_over.
// Ports  : clk        in  1          system clock
//          reset      in  1          synchronous, active-high reset
//          start      in  1          pulse: begin/restart play
//          pause      in  1          level: freeze scheduling while high
//          level_up   in  1          pulse: raise difficulty by one
//          game_over  in  1          pulse: frog hit, stop play
//          lane_tick  out NUM_LANES  one-hot, one-cycle move strobe
//          base_tick  out 1          one-cycle prescaler strobe
//          level      out LEVEL_W    current difficulty
//          running    out 1          high while in RUN
// Build  : CROSSY_SIM_FAST_EN defined -> 1-bit prescaler, base_tick every
//          2 RUN cycles (simulation); undefined -> full PRESCALE_W prescaler.
module lane_tick_scheduler
  import lane_sched_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int PRESCALE_W = 10,
  parameter int PERIOD_W   = 4,
  parameter int MAX_LEVEL  = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           level_up,
  input  logic                           game_over,
  output logic [NUM_LANES-1:0]           lane_tick,
  output logic                           base_tick,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level,
  output logic                           running
);

  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);
  localparam int PTR_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
`ifdef CROSSY_SIM_FAST_EN
  localparam int PS_W = 1;
`else
  localparam int PS_W = PRESCALE_W;
`endif

  sched_state_e          state;
  logic [PS_W-1:0]       prescaler;
  logic [PERIOD_W-1:0]   lane_cnt   [NUM_LANES];
  logic [PERIOD_W-1:0]   reload_cnt [NUM_LANES];
  logic [PERIOD_W-1:0]   start_cnt  [NUM_LANES];
  logic [NUM_LANES-1:0]  pending;
  logic [PTR_W-1:0]      rr_ptr;

  logic [NUM_LANES-1:0]  expire;
  logic [NUM_LANES-1:0]  grant;
  logic [NUM_LANES-1:0]  grant_ok;
  logic [PTR_W-1:0]      next_ptr;
  logic                  arb_en;

  // Counter reload value = period - 1, where period = base - level worked
  // out one bit wider than the counter so an over-large level shows up as a
  // negative result and is clamped rather than wrapping to a long period.
  function automatic logic [PERIOD_W-1:0] lane_reload(input int base,
                                                      input logic [LEVEL_W-1:0] lvl);
    logic [PERIOD_W:0] per;
    per = (PERIOD_W+1)'(base) - (PERIOD_W+1)'(lvl);
    if (per[PERIOD_W] || per < (PERIOD_W+1)'(MIN_PERIOD))
      per = (PERIOD_W+1)'(MIN_PERIOD);
    return PERIOD_W'(per - (PERIOD_W+1)'(1));
  endfunction

  assign base_tick = (state == RUN) && (&prescaler);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign reload_cnt[g] = lane_reload(BASE_PERIOD[g], level);
    assign start_cnt[g]  = lane_reload(BASE_PERIOD[g], '0);
    assign expire[g]     = base_tick && (lane_cnt[g] == '0);
  end

  // No grant in the cycle the FSM is leaving RUN, so nothing strobes once
  // PAUSE or OVER is entered; a held pending bit is served after resume.
  assign arb_en   = (state == RUN) && !game_over && !pause;
  assign grant_ok = arb_en ? grant : '0;

  rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req      (pending),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      level     <= '0;
      lane_tick <= '0;
      running   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) lane_cnt[i] <= '0;
    end else begin
      lane_tick <= '0;
      unique case (state)
        IDLE, OVER: begin
          pending <= '0;
          if (start) begin
            state     <= RUN;
            running   <= 1'b1;
            level     <= '0;
            prescaler <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < NUM_LANES; i++) lane_cnt[i] <= start_cnt[i];
          end
        end

        RUN: begin
          prescaler <= prescaler + 1'b1;
          if (base_tick) begin
            for (int i = 0; i < NUM_LANES; i++)
              lane_cnt[i] <= expire[i] ? reload_cnt[i] : lane_cnt[i] - 1'b1;
          end
          // A fresh expiry outranks the grant that clears the same lane.
          pending <= (pending & ~grant_ok) | expire;
          if (|grant_ok) begin
            lane_tick <= grant_ok;
            rr_ptr    <= next_ptr;
          end
          if (level_up && level != LEVEL_W'(MAX_LEVEL)) level <= level + 1'b1;
          if (game_over) begin
            state   <= OVER;
            running <= 1'b0;
            pending <= '0;
          end else if (pause) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end

        PAUSE: begin
          if (level_up && level != LEVEL_W'(MAX_LEVEL)) level <= level + 1'b1;
          if (game_over) begin
            state   <= OVER;
            pending <= '0;
          end else if (!pause) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lane_tick_scheduler.md
Name: lane_tick_scheduler

Overview:
- Generates per-lane car-move strobes for the road lanes.
- Owns the slow-tick prescaler and one period down-counter per lane.
- Grants at most one lane move per cycle, round-robin, so the shared lane-shift/LED update logic is never double-booked.
- Sits between the top-level game FSM (start/pause/level/game over) and the lane shift registers.

Parameters:
- NUM_LANES, 4, number of car lanes scheduled.
- PRESCALE_W, 10, prescaler width; base_tick once per 2^PRESCALE_W cycles.
- PERIOD_W, 4, width of lane period counters.
- MAX_LEVEL, 7, highest difficulty level; level saturates here.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin/restart play.
- pause  in  1  level: freeze scheduling while high.
- level_up  in  1  pulse: raise difficulty by one.
- game_over  in  1  pulse: frog hit; stop play.
- lane_tick  out  NUM_LANES  one-hot, one-cycle move strobe per lane.
- base_tick  out  1  one-cycle prescaler strobe (debug/frog timing).
- level  out  $clog2(MAX_LEVEL+1)  current difficulty.
- running  out  1  high in RUN state.

Behaviour:
- Reset: state IDLE; prescaler, lane counters, pending, rr_ptr and level cleared to 0; all outputs 0.
- FSM states: IDLE, RUN, PAUSE, OVER.
- Input priority within one cycle: game_over > pause > start.
  - IDLE: start -> RUN.
  - RUN: game_over -> OVER; else pause -> PAUSE.
  - PAUSE: game_over -> OVER; else !pause -> RUN.
  - OVER: start -> RUN, with level reset to 0.
- On entry to RUN from IDLE/OVER: prescaler = 0, pending = 0, rr_ptr = 0, each lane_cnt[i] = period(i)-1.
- Prescaler: increments only in RUN and wraps naturally. base_tick = RUN && prescaler == all-ones.
- Lane period:
  - period(i) = BASE_PERIOD[i] - level, computed in PERIOD_W+1 bits, clamped to a minimum of 1.
  - A level change affects only the next reload; in-flight counts are untouched.
- Per lane, on base_tick: if lane_cnt == 0, set pending[i] and reload period(i)-1; else decrement.
- Pending is one bit per lane. A repeat expiry while pending coalesces (no queue). If set and clear hit the same lane in the same cycle, set wins.
- Arbiter (RUN only):
  - If pending != 0, pick the first set bit searching from rr_ptr upward with wrap.
  - Clear that bit, set rr_ptr = grant+1 mod NUM_LANES, and register lane_tick one-hot.
  - Latency: expiry -> lane_tick is 1 cycle minimum, NUM_LANES cycles worst case.
- PAUSE: prescaler, lane_cnt, pending and rr_ptr held; lane_tick = 0; base_tick = 0.
- OVER: everything frozen, pending cleared, lane_tick = 0.
- level_up: accepted in RUN or PAUSE; level+1, saturating at MAX_LEVEL. Ignored in IDLE/OVER.
- Reset mid-play: returns to IDLE next edge; any in-flight lane_tick is dropped.
- running is registered and equals (state == RUN).

Optional Feature:
- Macro CROSSY_SIM_FAST_EN.
- Defined: effective prescaler width is 1, so base_tick occurs every 2 RUN cycles (simulation).
- Undefined: full PRESCALE_W width (board).
- All other behaviour identical.

Decomposition:
- Package lane_sched_pkg holds:
  - state enum sched_state_e {IDLE, RUN, PAUSE, OVER};
  - BASE_PERIOD constant array, default {8, 6, 10, 5};
  - MIN_PERIOD = 1.
- One natural sub-module: rr_arbiter, parameterised NUM_LANES. Inputs: req vector, rr_ptr. Outputs: one-hot grant, next_ptr. Purely combinational; registered in the parent.

Test Plan (with CROSSY_SIM_FAST_EN):
- Reset then start, level 0 -> lane0 counter loaded with 7. pending[0] sets on the 8th base_tick (cycle 16 after RUN entry); lane_tick = 4'b0001 on the next cycle.
- Force lanes 0, 1 and 3 pending in the same cycle with rr_ptr = 0 -> lane_tick = 0001, 0010, 1000 on consecutive cycles; rr_ptr ends at 0.
- pause high for 20 cycles mid-count -> no base_tick or lane_tick during pause; after release, the next expiry occurs exactly 20 cycles later than without the pause.
- level_up ×9 from level 0 -> level saturates at 7. Lane3 period clamps to 1 (5-7 < 1), so lane3 becomes pending on every base_tick.
- Assert game_over and pause together in RUN -> state OVER, pending = 0, lane_tick = 0. A following start -> RUN with level = 0.
- Assert reset during a lane_tick pulse -> next cycle all outputs 0, state IDLE; start is required to resume.
